// File: rtl/logic_analyzer_readout_sequencer.sv
// Streams a window of the sample BRAM onto a valid/ready stream, starting at a
// base pointer, wrapping modulo SAMPLE_DEPTH, with credit-limited read issue.
module logic_analyzer_readout_sequencer #(
  parameter int SAMPLE_DEPTH = 1024,
  parameter int SAMPLE_WIDTH = 8,
  parameter int READ_LATENCY = 2,
  parameter int FIFO_DEPTH   = 4,
  localparam int ADDR_WIDTH  = $clog2(SAMPLE_DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   base_addr,
  input  logic [ADDR_WIDTH:0]     count,
  output logic [ADDR_WIDTH-1:0]   bram_addr,
  output logic                    bram_en,
  input  logic [SAMPLE_WIDTH-1:0] bram_dout,
  output logic [SAMPLE_WIDTH-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic                    busy,
  output logic                    done
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = (ADDR_WIDTH + 1)'(SAMPLE_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(SAMPLE_DEPTH - 1);
  localparam logic [PTR_W-1:0]      LAST_PTR  = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W:0]        FIFO_CAP  = (CNT_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t state, state_next;

  logic                    start_q;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [ADDR_WIDTH:0]     count_lat;
  logic [ADDR_WIDTH:0]     issued;
  logic [READ_LATENCY-1:0] en_pipe;
  logic [READ_LATENCY-1:0] last_pipe;
  logic [CNT_W-1:0]        in_flight;
  logic [CNT_W-1:0]        fifo_count;
  logic [PTR_W-1:0]        rd_ptr;
  logic [PTR_W-1:0]        wr_ptr;
  logic [SAMPLE_WIDTH-1:0] fifo_data [FIFO_DEPTH];
  logic                    fifo_last [FIFO_DEPTH];

  logic start_rise;
  logic credit_ok;
  logic is_last_issue;
  logic issue;
  logic push;
  logic pop;

  assign start_rise    = start & ~start_q;
  // Credits cover both the FIFO contents and reads still travelling through the BRAM.
  assign credit_ok     = ({1'b0, in_flight} + {1'b0, fifo_count}) < FIFO_CAP;
  assign is_last_issue = (issued + (ADDR_WIDTH + 1)'(1)) == count_lat;
  assign push          = en_pipe[READ_LATENCY-1];
  assign pop           = out_valid & out_ready;

  assign bram_en   = issue;
  assign bram_addr = addr;
  assign busy      = (state != IDLE);
  assign done      = (state == FINISH);
  assign out_valid = (fifo_count != {CNT_W{1'b0}});
  assign out_data  = fifo_data[rd_ptr];
  assign out_last  = out_valid & fifo_last[rd_ptr];

  always_comb begin
    state_next = state;
    issue      = 1'b0;
    case (state)
      IDLE: begin
        if (start_rise) state_next = ISSUE;
        else            state_next = IDLE;
      end
      ISSUE: begin
        // A zero-length window leaves ISSUE without ever enabling the BRAM.
        if (issued == count_lat) begin
          state_next = FINISH;
        end else if (credit_ok) begin
          issue = 1'b1;
          if (is_last_issue) state_next = DRAIN;
          else               state_next = ISSUE;
        end else begin
          state_next = ISSUE;
        end
      end
      DRAIN: begin
        if (pop && out_last) state_next = FINISH;
        else                 state_next = DRAIN;
      end
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      start_q   <= 1'b0;
      addr      <= {ADDR_WIDTH{1'b0}};
      count_lat <= {(ADDR_WIDTH + 1){1'b0}};
      issued    <= {(ADDR_WIDTH + 1){1'b0}};
    end else begin
      state   <= state_next;
      start_q <= start;
      if (state == IDLE && start_rise) begin
        addr      <= base_addr;
        count_lat <= (count > DEPTH_CNT) ? DEPTH_CNT : count;
        issued    <= {(ADDR_WIDTH + 1){1'b0}};
      end else if (issue) begin
        addr   <= (addr == LAST_ADDR) ? {ADDR_WIDTH{1'b0}} : addr + 1'b1;
        issued <= issued + (ADDR_WIDTH + 1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en_pipe   <= {READ_LATENCY{1'b0}};
      last_pipe <= {READ_LATENCY{1'b0}};
      in_flight <= {CNT_W{1'b0}};
    end else begin
      en_pipe   <= (en_pipe << 1) | READ_LATENCY'(issue);
      last_pipe <= (last_pipe << 1) | READ_LATENCY'(issue & is_last_issue);
      case ({issue, push})
        2'b10:   in_flight <= in_flight + 1'b1;
        2'b01:   in_flight <= in_flight - 1'b1;
        default: in_flight <= in_flight;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr     <= {PTR_W{1'b0}};
      wr_ptr     <= {PTR_W{1'b0}};
      fifo_count <= {CNT_W{1'b0}};
    end else begin
      if (push) wr_ptr <= (wr_ptr == LAST_PTR) ? {PTR_W{1'b0}} : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? {PTR_W{1'b0}} : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Storage needs no reset: the head is only observed while fifo_count is non-zero.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= bram_dout;
      fifo_last[wr_ptr] <= last_pipe[READ_LATENCY-1];
    end
  end

endmodule

// File: tb/tb_logic_analyzer_readout_sequencer.sv
// Randomized bench for the readout sequencer: a BRAM model feeds the DUT and every
// window is compared against an expected sample list built from the memory contents.
module tb_logic_analyzer_readout_sequencer;

  localparam int DEPTH = 1024;
  localparam int FD    = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [9:0] base_addr;
  logic [10:0] count;
  logic [9:0] bram_addr;
  logic       bram_en;
  logic [7:0] bram_dout;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       busy;
  logic       done;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [7:0] mem [DEPTH];
  logic [7:0] p1;

  // monitor state
  int en_total, xfer, first_en, first_valid, last_en_cyc, last_xfer_cyc;
  int done_cnt, done_cyc, max_occ, last_viol, stab_viol;
  bit done_seen, prev_stall;
  logic [7:0] prev_data;
  logic prev_last;
  logic [7:0] rx_data [$];
  bit rx_last [$];
  logic [9:0] en_addrs [$];

  int t0;
  bit timed_out;

  logic_analyzer_readout_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .count(count),
    .bram_addr(bram_addr), .bram_en(bram_en), .bram_dout(bram_dout),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Two-stage BRAM read: data valid two cycles after the enable cycle.
  always @(posedge clk) begin
    if (bram_en) p1 <= mem[bram_addr];
    bram_dout <= p1;
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (bram_en) begin
        en_total <= en_total + 1;
        en_addrs.push_back(bram_addr);
        last_en_cyc <= cyc;
        if (first_en < 0) first_en <= cyc;
      end
      if (out_valid && out_ready) begin
        xfer <= xfer + 1;
        rx_data.push_back(out_data);
        rx_last.push_back(out_last);
        last_xfer_cyc <= cyc;
      end
      if (out_valid && first_valid < 0) first_valid <= cyc;
      if ((en_total + int'(bram_en)) - (xfer + int'(out_valid && out_ready)) > max_occ)
        max_occ <= (en_total + int'(bram_en)) - (xfer + int'(out_valid && out_ready));
      if (out_last && !out_valid) last_viol <= last_viol + 1;
      if (prev_stall && (!out_valid || out_data !== prev_data || out_last !== prev_last))
        stab_viol <= stab_viol + 1;
      prev_stall <= out_valid && !out_ready;
      prev_data  <= out_data;
      prev_last  <= out_last;
      if (done) begin
        done_cnt  <= done_cnt + 1;
        done_cyc  <= cyc;
        done_seen <= 1'b1;
      end
    end else begin
      prev_stall <= 1'b0;
    end
  end

  task automatic arm();
    en_total = 0; xfer = 0; first_en = -1; first_valid = -1; last_en_cyc = -1;
    last_xfer_cyc = -1; done_cnt = 0; done_cyc = -1; max_occ = 0; last_viol = 0;
    stab_viol = 0; done_seen = 1'b0;
    rx_data.delete(); rx_last.delete(); en_addrs.delete();
  endtask

  // Expected window: n samples of mem starting at b, modulo DEPTH, last flag on the final one.
  // Returns -1 on an exact match, otherwise the first offending index.
  function automatic int scoreboard_diff(int b, int n);
    for (int i = 0; i < n; i++) begin
      if (i >= rx_data.size()) return i;
      if (rx_data[i] !== mem[(b + i) % DEPTH]) return i;
      if (rx_last[i] !== (i == n - 1)) return i;
    end
    if (rx_data.size() != n) return n;
    return -1;
  endfunction

  function automatic int clamp_count(int c);
    return (c > DEPTH) ? DEPTH : c;
  endfunction

  // mode 1: keep start high throughout and re-pulse it while the window is busy.
  task automatic do_window(input int b, input int c, input int pct, input int mode);
    arm();
    @(posedge clk); #1;
    base_addr = 10'(b);
    count     = 11'(c);
    start     = 1'b1;
    out_ready = (pct >= 100) ? 1'b1 : ($urandom_range(99) < pct);
    t0        = cyc;
    timed_out = 1'b1;
    for (int k = 0; k < 5000; k++) begin
      @(posedge clk); #1;
      if (mode == 0)       start = 1'b0;
      else if (k == 10)    start = 1'b0;
      else if (k == 11)    start = 1'b1;
      out_ready = (pct >= 100) ? 1'b1 : ($urandom_range(99) < pct);
      if (done_seen) begin
        timed_out = 1'b0;
        break;
      end
    end
    if (mode == 0) start = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; base_addr = '0; count = '0; out_ready = 1'b1;
    arm();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bram_en, out_valid, out_last, busy, done} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs: got en/valid/last/busy/done=%b, want 00000",
               {bram_en, out_valid, out_last, busy, done});
    end
    checks++;
    if (bram_addr !== 10'd0) begin
      errors++;
      $display("FAIL reset_addr: got %0d, want 0", bram_addr);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int d;
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'(i);
    do_window(0, 8, 100, 0);
    d = scoreboard_diff(0, 8);
    checks++;
    if (timed_out) begin errors++; $display("FAIL basic_timeout: no done within budget"); end
    checks++;
    if (d != -1) begin errors++; $display("FAIL basic_data: first bad index %0d of %0d received", d, rx_data.size()); end
    checks++;
    if (first_en != t0 + 1) begin errors++; $display("FAIL basic_first_en: got cycle %0d, want %0d", first_en - t0, 1); end
    checks++;
    if (first_valid != t0 + 4) begin errors++; $display("FAIL basic_first_valid: got cycle %0d, want %0d", first_valid - t0, 4); end
    checks++;
    if (last_xfer_cyc - first_valid != 7) begin errors++; $display("FAIL basic_no_bubbles: span %0d, want 7", last_xfer_cyc - first_valid); end
    checks++;
    if (done_cyc != last_xfer_cyc + 1 || done_cnt != 1) begin
      errors++; $display("FAIL basic_done: at %0d count %0d, want at %0d count 1", done_cyc, done_cnt, last_xfer_cyc + 1);
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after: got %b, want 0", busy); end
  endtask

  task automatic test_wrap();
    int d;
    int bad;
    do_window(1020, 8, 100, 0);
    bad = -1;
    for (int i = 0; i < 8; i++)
      if (i >= en_addrs.size() || en_addrs[i] !== 10'((1020 + i) % DEPTH)) begin bad = i; break; end
    checks++;
    if (bad != -1 || en_addrs.size() != 8) begin
      errors++; $display("FAIL wrap_addr: first bad index %0d, %0d reads, want 8 reads 1020..3", bad, en_addrs.size());
    end
    d = scoreboard_diff(1020, 8);
    checks++;
    if (timed_out || d != -1) begin errors++; $display("FAIL wrap_data: first bad index %0d timeout %0b", d, timed_out); end
  endtask

  task automatic test_backpressure();
    int b, d;
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom);
    b = $urandom_range(DEPTH - 1);
    do_window(b, 64, 30, 0);
    d = scoreboard_diff(b, 64);
    checks++;
    if (timed_out || d != -1) begin errors++; $display("FAIL bp_data: first bad index %0d of %0d received, timeout %0b", d, rx_data.size(), timed_out); end
    checks++;
    if (max_occ > FD) begin errors++; $display("FAIL bp_overflow: outstanding reached %0d, limit %0d", max_occ, FD); end
    checks++;
    if (stab_viol != 0 || last_viol != 0) begin
      errors++; $display("FAIL bp_stability: %0d unstable stalls, %0d stray last, want 0/0", stab_viol, last_viol);
    end
    checks++;
    if (en_total != 64 || last_en_cyc - first_en + 1 <= 64) begin
      errors++; $display("FAIL bp_issue_stall: %0d reads over %0d cycles, want 64 reads with stalls", en_total, last_en_cyc - first_en + 1);
    end
  endtask

  task automatic test_edge_counts();
    int b, d;
    b = $urandom_range(DEPTH - 1);
    do_window(b, 0, 100, 0);
    checks++;
    if (timed_out || done_cyc != t0 + 2 || done_cnt != 1) begin
      errors++; $display("FAIL zero_done: at cycle %0d count %0d, want cycle 2 count 1", done_cyc - t0, done_cnt);
    end
    checks++;
    if (first_en != -1 || first_valid != -1) begin
      errors++; $display("FAIL zero_activity: en at %0d valid at %0d, want none", first_en, first_valid);
    end
    do_window(b, 2000, 100, 0);
    d = scoreboard_diff(b, clamp_count(2000));
    checks++;
    if (timed_out || xfer != 1024 || en_total != 1024) begin
      errors++; $display("FAIL clamp_count: %0d transfers %0d reads, want 1024", xfer, en_total);
    end
    checks++;
    if (d != -1) begin errors++; $display("FAIL clamp_data: first bad index %0d", d); end
  endtask

  task automatic test_reset_mid();
    int d;
    bit reached;
    arm();
    @(posedge clk); #1;
    base_addr = 10'd0; count = 11'd64; start = 1'b1; out_ready = 1'b1;
    reached = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (xfer >= 5) begin reached = 1'b1; break; end
    end
    checks++;
    if (!reached) begin errors++; $display("FAIL mid_reach: only %0d transfers, want 5", xfer); end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bram_en, out_valid, out_last, busy, done} !== 5'b0) begin
      errors++; $display("FAIL mid_reset_outputs: got en/valid/last/busy/done=%b, want 00000",
                         {bram_en, out_valid, out_last, busy, done});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    arm();
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (first_valid != -1 || en_total != 0) begin
      errors++; $display("FAIL mid_stale: valid at %0d, %0d reads after reset, want none", first_valid, en_total);
    end
    do_window(0, 4, 100, 0);
    d = scoreboard_diff(0, 4);
    checks++;
    if (timed_out || d != -1 || en_total != 4) begin
      errors++; $display("FAIL mid_restart: first bad index %0d, %0d reads, timeout %0b", d, en_total, timed_out);
    end
  endtask

  task automatic test_start_ignored();
    int b, d;
    b = $urandom_range(DEPTH - 1);
    do_window(b, 32, 100, 1);
    repeat (10) @(posedge clk);
    #1;
    d = scoreboard_diff(b, 32);
    checks++;
    if (timed_out || d != -1) begin errors++; $display("FAIL hold_data: first bad index %0d timeout %0b", d, timed_out); end
    checks++;
    if (en_total != 32 || done_cnt != 1 || busy !== 1'b0) begin
      errors++; $display("FAIL hold_single_window: %0d reads %0d done busy=%b, want 32/1/0", en_total, done_cnt, busy);
    end
    start = 1'b0;
  endtask

  task automatic test_random();
    int b, c, p, d;
    for (int r = 0; r < 3; r++) begin
      b = $urandom_range(DEPTH - 1);
      c = $urandom_range(100, 1);
      p = $urandom_range(100, 40);
      do_window(b, c, p, 0);
      d = scoreboard_diff(b, c);
      checks++;
      if (timed_out || d != -1 || max_occ > FD) begin
        errors++; $display("FAIL random_window: base %0d count %0d ready %0d%%: bad index %0d occ %0d timeout %0b",
                           b, c, p, d, max_occ, timed_out);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_edge_counts();
    test_reset_mid();
    test_start_ignored();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
